// File: rtl/guess_checker.sv
// guess_checker
//
// Target/guess comparator for the number-guessing game. A start pulse latches
// the current RNG value as the secret target and arms MAX_TRIES attempts. Each
// accepted guess is evaluated one cycle later (CHECK) and reported as tooHigh,
// tooLow or correct. The game ends in WIN on a match or in LOSE when the
// attempts run out. While the game is over, the target is shown on reveal.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   rngValue     in   [3:0] RNG output, sampled on an accepted start
//   startGame    in   active-low one-cycle start/restart pulse (highest priority)
//   guessValue   in   [3:0] player guess, sampled on an accepted submit
//   guessSubmit  in   active-low one-cycle submit pulse
//   tooHigh      out  last evaluated guess > target
//   tooLow       out  last evaluated guess < target
//   correct      out  last evaluated guess == target
//   gameOver     out  high in WIN or LOSE
//   attemptsLeft out  [2:0] remaining guesses
//   reveal       out  [3:0] target while gameOver, else 0
module guess_checker #(
  parameter int MAX_TRIES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rngValue,
  input  logic       startGame,
  input  logic [3:0] guessValue,
  input  logic       guessSubmit,
  output logic       tooHigh,
  output logic       tooLow,
  output logic       correct,
  output logic       gameOver,
  output logic [2:0] attemptsLeft,
  output logic [3:0] reveal
);

  localparam logic [2:0] LP_MAX_TRIES = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_target;
  logic [3:0] w_target_nxt;
  logic [3:0] r_guess;
  logic [3:0] w_guess_nxt;
  logic [2:0] r_left;
  logic [2:0] w_left_nxt;
  logic [2:0] w_left_dec;
  logic       r_high;
  logic       w_high_nxt;
  logic       r_low;
  logic       w_low_nxt;
  logic       r_correct;
  logic       w_correct_nxt;

  // Attempt counter never wraps below zero.
  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  assign w_left_dec = sat_dec(r_left);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_target  <= '0;
      r_guess   <= '0;
      r_left    <= '0;
      r_high    <= 1'b0;
      r_low     <= 1'b0;
      r_correct <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_target  <= w_target_nxt;
      r_guess   <= w_guess_nxt;
      r_left    <= w_left_nxt;
      r_high    <= w_high_nxt;
      r_low     <= w_low_nxt;
      r_correct <= w_correct_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_target_nxt  = r_target;
    w_guess_nxt   = r_guess;
    w_left_nxt    = r_left;
    w_high_nxt    = r_high;
    w_low_nxt     = r_low;
    w_correct_nxt = r_correct;

    if (!startGame) begin
      // A start overrides everything, including a CHECK in flight and a
      // simultaneous submit.
      w_target_nxt  = rngValue;
      w_left_nxt    = LP_MAX_TRIES;
      w_high_nxt    = 1'b0;
      w_low_nxt     = 1'b0;
      w_correct_nxt = 1'b0;
      w_state_nxt   = S_WAIT;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (!guessSubmit) begin
            w_guess_nxt = guessValue;
            w_state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_guess == r_target) begin
            w_correct_nxt = 1'b1;
            w_high_nxt    = 1'b0;
            w_low_nxt     = 1'b0;
            w_state_nxt   = S_WIN;
          end else begin
            w_correct_nxt = 1'b0;
            w_high_nxt    = (r_guess > r_target);
            w_low_nxt     = (r_guess < r_target);
            w_left_nxt    = w_left_dec;
            w_state_nxt   = (w_left_dec == 3'd0) ? S_LOSE : S_WAIT;
          end
        end
        // IDLE, WIN and LOSE wait for a start; submits are ignored.
        default: w_state_nxt = r_state;
      endcase
    end
  end

  assign tooHigh      = r_high;
  assign tooLow       = r_low;
  assign correct      = r_correct;
  assign attemptsLeft = r_left;
  assign gameOver     = (r_state == S_WIN) || (r_state == S_LOSE);
  assign reveal       = gameOver ? r_target : 4'd0;

endmodule

// File: tb/tb_guess_checker.sv
module tb_guess_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rngValue = 4'd0;
  logic       startGame = 1'b1;
  logic [3:0] guessValue = 4'd0;
  logic       guessSubmit = 1'b1;

  logic       hi4, lo4, cor4, go4;
  logic [2:0] left4;
  logic [3:0] rev4;
  logic       hi1, lo1, cor1, go1;
  logic [2:0] left1;
  logic [3:0] rev1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  guess_checker #(.MAX_TRIES(4)) u_dut4 (
    .clk(clk), .rst(rst), .rngValue(rngValue), .startGame(startGame),
    .guessValue(guessValue), .guessSubmit(guessSubmit),
    .tooHigh(hi4), .tooLow(lo4), .correct(cor4), .gameOver(go4),
    .attemptsLeft(left4), .reveal(rev4)
  );

  guess_checker #(.MAX_TRIES(1)) u_dut1 (
    .clk(clk), .rst(rst), .rngValue(rngValue), .startGame(startGame),
    .guessValue(guessValue), .guessSubmit(guessSubmit),
    .tooHigh(hi1), .tooLow(lo1), .correct(cor1), .gameOver(go1),
    .attemptsLeft(left1), .reveal(rev1)
  );

  function automatic int pack(input bit h, input bit l, input bit c, input bit g,
                              input int left, input int rev);
    return (int'(h) << 13) | (int'(l) << 12) | (int'(c) << 11) | (int'(g) << 10) |
           ((left & 7) << 4) | (rev & 15);
  endfunction

  function automatic int dut_out(input int k);
    if (k == 0) return pack(hi4, lo4, cor4, go4, int'(left4), int'(rev4));
    return pack(hi1, lo1, cor1, go1, int'(left1), int'(rev1));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string name, input int k, input bit h, input bit l,
                            input bit c, input bit g, input int left, input int rev);
    chk($sformatf("%s[max=%0d]", name, (k == 0) ? 4 : 1), dut_out(k),
        pack(h, l, c, g, left, rev));
  endtask

  // Behavioural reference: a game is either waiting for a guess, holding a
  // guess to judge on the next edge, or over; anything else is idle.
  int       m_max [2] = '{4, 1};
  int       m_left[2] = '{0, 0};
  bit       m_hi  [2] = '{0, 0};
  bit       m_lo  [2] = '{0, 0};
  bit       m_cor [2] = '{0, 0};
  bit       m_over[2] = '{0, 0};
  bit       m_wait[2] = '{0, 0};
  bit       m_pend[2] = '{0, 0};
  int       m_tgt [2] = '{0, 0};
  int       m_g   [2] = '{0, 0};

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_left[k] = 0; m_hi[k] = 0; m_lo[k] = 0; m_cor[k] = 0;
        m_over[k] = 0; m_wait[k] = 0; m_pend[k] = 0; m_tgt[k] = 0; m_g[k] = 0;
      end else if (!startGame) begin
        m_tgt[k] = int'(rngValue); m_left[k] = m_max[k];
        m_hi[k] = 0; m_lo[k] = 0; m_cor[k] = 0;
        m_over[k] = 0; m_wait[k] = 1; m_pend[k] = 0;
      end else if (m_pend[k]) begin
        m_pend[k] = 0;
        if (m_g[k] == m_tgt[k]) begin
          m_cor[k] = 1; m_hi[k] = 0; m_lo[k] = 0; m_over[k] = 1;
        end else begin
          m_cor[k] = 0;
          m_hi[k]  = (m_g[k] > m_tgt[k]);
          m_lo[k]  = (m_g[k] < m_tgt[k]);
          if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) m_over[k] = 1;
          else m_wait[k] = 1;
        end
      end else if (m_wait[k] && !guessSubmit) begin
        m_g[k] = int'(guessValue); m_pend[k] = 1; m_wait[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      chk($sformatf("model_cmp[max=%0d]", m_max[k]), dut_out(k),
          pack(m_hi[k], m_lo[k], m_cor[k], m_over[k], m_left[k],
               m_over[k] ? m_tgt[k] : 0));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] v);
    rngValue = v; startGame = 1'b0;
    cyc();
    startGame = 1'b1;
  endtask

  task automatic do_guess(input logic [3:0] v);
    guessValue = v; guessSubmit = 1'b0;
    cyc();
    guessSubmit = 1'b1;
    cyc();
  endtask

  initial begin
    // Reset from power-up.
    #1 rst = 1'b0;
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset", 1, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    cyc();

    // Submit in IDLE is ignored.
    do_guess(4'd7);
    expect_out("idle_submit", 0, 0, 0, 0, 0, 0, 0);

    // Win path, and MAX_TRIES=1 losing after one miss.
    do_start(4'd9);
    expect_out("start9", 0, 0, 0, 0, 0, 4, 0);
    expect_out("start9", 1, 0, 0, 0, 0, 1, 0);
    guessValue = 4'd3; guessSubmit = 1'b0;
    cyc();
    guessSubmit = 1'b1;
    expect_out("latency_one_edge", 0, 0, 0, 0, 0, 4, 0);
    cyc();
    expect_out("win_g3_low", 0, 0, 1, 0, 0, 3, 0);
    expect_out("max1_lose", 1, 0, 1, 0, 1, 0, 9);
    do_guess(4'd12);
    expect_out("win_g12_high", 0, 1, 0, 0, 0, 2, 0);
    expect_out("max1_hold", 1, 0, 1, 0, 1, 0, 9);
    do_guess(4'd9);
    expect_out("win_g9_correct", 0, 0, 0, 1, 1, 2, 9);
    chk("model_win_left", m_left[0], 2);

    // Restart from WIN.
    do_start(4'd5);
    expect_out("restart5", 0, 0, 0, 0, 0, 4, 0);
    do_guess(4'd5);
    expect_out("restart_correct", 0, 0, 0, 1, 1, 4, 5);
    expect_out("restart_correct", 1, 0, 0, 1, 1, 1, 5);

    // Lose path.
    do_start(4'd0);
    do_guess(4'd1);
    expect_out("lose_g1", 0, 1, 0, 0, 0, 3, 0);
    expect_out("lose_g1", 1, 1, 0, 0, 1, 0, 0);
    do_guess(4'd2);
    expect_out("lose_g2", 0, 1, 0, 0, 0, 2, 0);
    do_guess(4'd3);
    expect_out("lose_g3", 0, 1, 0, 0, 0, 1, 0);
    do_guess(4'd15);
    expect_out("lose_g15", 0, 1, 0, 0, 1, 0, 0);
    chk("model_lose_over", int'(m_over[0]), 1);
    do_guess(4'd0);
    expect_out("lose_fifth", 0, 1, 0, 0, 1, 0, 0);

    // Unsigned extremes.
    do_start(4'd15);
    do_guess(4'd0);
    expect_out("tgt15_g0", 0, 0, 1, 0, 0, 3, 0);
    do_start(4'd0);
    do_guess(4'd15);
    expect_out("tgt0_g15", 0, 1, 0, 0, 0, 3, 0);

    // Submit held into CHECK is dropped.
    do_start(4'd8);
    guessValue = 4'd2; guessSubmit = 1'b0;
    cyc();
    guessValue = 4'd3;
    cyc();
    guessSubmit = 1'b1;
    expect_out("check_submit", 0, 0, 1, 0, 0, 3, 0);
    cyc();
    cyc();
    expect_out("check_submit_after", 0, 0, 1, 0, 0, 3, 0);

    // Simultaneous start and submit: start wins.
    rngValue = 4'd4; guessValue = 4'd4;
    startGame = 1'b0; guessSubmit = 1'b0;
    cyc();
    startGame = 1'b1; guessSubmit = 1'b1;
    expect_out("simul", 0, 0, 0, 0, 0, 4, 0);
    cyc();
    expect_out("simul_after", 0, 0, 0, 0, 0, 4, 0);

    // Start during CHECK discards the result.
    guessValue = 4'd1; guessSubmit = 1'b0;
    cyc();
    guessSubmit = 1'b1; rngValue = 4'd6; startGame = 1'b0;
    cyc();
    startGame = 1'b1;
    expect_out("start_in_check", 0, 0, 0, 0, 0, 4, 0);
    cyc();
    expect_out("start_in_check_after", 0, 0, 0, 0, 0, 4, 0);

    // Asynchronous reset mid-WAIT, then submits do nothing.
    do_guess(4'd0);
    #2 rst = 1'b0;
    #1;
    expect_out("async_reset", 0, 0, 0, 0, 0, 0, 0);
    expect_out("async_reset", 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    do_guess(4'd6);
    do_guess(4'd6);
    expect_out("post_reset_submit", 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rngValue    = 4'($urandom);
      guessValue  = 4'($urandom);
      startGame   = ($urandom_range(0, 15) != 0);
      guessSubmit = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
      cyc();
    end
    startGame = 1'b1; guessSubmit = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
